// File: rtl/sram_port_arbiter.sv
// Arbitrates the single SRAM port between instruction fetch and data memory.
// Define SRAM_ARB_RR_EN for round-robin arbitration instead of fixed MEM-over-IF priority.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stall_if,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_be,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    output logic              stall_mem,
    input  logic              flush,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyMem} state_e;

    localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              mem_valid_q, mem_valid_d;

    logic if_pend, mem_pend, grant_if, grant_mem;

`ifdef SRAM_ARB_RR_EN
    logic last_if_q, last_if_d;

    always_comb begin
        last_if_d = last_if_q;
        if (state_q == StIdle && (grant_if || grant_mem)) begin
            last_if_d = grant_if;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_if_q <= 1'b0;
        end else begin
            last_if_q <= last_if_d;
        end
    end
`endif

    // A requester whose completion is pulsing this cycle is not re-granted.
    always_comb begin
        if_pend  = if_req && !if_valid_q;
        mem_pend = mem_req && !mem_valid_q;
`ifdef SRAM_ARB_RR_EN
        grant_if = if_pend && (!mem_pend || !last_if_q);
`else
        grant_if = if_pend && !mem_pend;
`endif
        grant_mem = mem_pend && !grant_if;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        addr_d      = addr_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_mem) begin
                    state_d = StBusyMem;
                    cnt_d   = 4'd0;
                    addr_d  = mem_addr;
                    we_d    = mem_we;
                    be_d    = mem_be;
                    wdata_d = mem_wdata;
                end else if (grant_if) begin
                    state_d = StBusyIf;
                    cnt_d   = 4'd0;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    be_d    = 4'b0;
                    wdata_d = '0;
                    drop_d  = flush;
                end
            end
            StBusyIf: begin
                cnt_d = cnt_q + 4'd1;
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (cnt_q == LastCnt) begin
                    state_d    = StIdle;
                    cnt_d      = 4'd0;
                    if_rdata_d = sram_rdata;
                    // A flush on the last cycle still kills the fetch.
                    if_valid_d = !(drop_q || flush);
                    drop_d     = 1'b0;
                end
            end
            StBusyMem: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LastCnt) begin
                    state_d     = StIdle;
                    cnt_d       = 4'd0;
                    mem_rdata_d = we_q ? '0 : sram_rdata;
                    mem_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            drop_q      <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= 4'b0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    always_comb begin
        sram_en    = (state_q != StIdle);
        sram_we    = (sram_en && we_q) ? be_q : 4'b0;
        sram_addr  = addr_q;
        sram_wdata = wdata_q;
        if_rdata   = if_rdata_q;
        mem_rdata  = mem_rdata_q;
        if_valid   = if_valid_q;
        mem_valid  = mem_valid_q;
        stall_if   = if_req && !if_valid_q;
        stall_mem  = mem_req && !mem_valid_q;
    end

endmodule
